// File: rtl/apb_reg_pkg.sv
// Shared types and helpers for the APB register slave: bus FSM states,
// word-offset shift and the byte-address decode.
package apb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Byte address to word index: registers are 32-bit, so drop two bits.
    localparam int WORD_SHIFT = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } decode_t;

    // A byte address hits a register only when it is word aligned and its
    // word offset lies inside the bank; n_regs is a power of two, so the
    // index is the word offset masked to the bank size.
    function automatic decode_t decode_addr(input logic [63:0] addr, input int n_regs);
        decode_t     d;
        logic [63:0] word;
        word    = addr >> WORD_SHIFT;
        d.valid = (addr[1:0] == 2'b00) && (word < 64'(n_regs));
        d.idx   = 32'(word & 64'(n_regs - 1));
        return d;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage: N_REGS words with a byte-enable write port and a
// combinational read port, cleared synchronously on preset.
module apb_reg_bank #(
    parameter  int N_REGS     = 8,
    parameter  int REGS_WIDTH = 32,
    localparam int IDX_W      = $clog2(N_REGS),
    localparam int STRB_W     = REGS_WIDTH / 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [REGS_WIDTH-1:0] wr_data,
    input  logic [STRB_W-1:0]     wr_strb,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [REGS_WIDTH-1:0] rd_data
);

    logic [REGS_WIDTH-1:0] mem [N_REGS];

    // Clear every word on reset, otherwise merge enabled bytes into one word.
    // NOTE: resetting the whole array makes this a flop bank, never a RAM;
    // registers must read 0 after reset, so that is intended here.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < N_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_reg_slave.sv
// APB4 completer with a bank of word registers, zero wait states.
// state_q names the bus phase sampled at the last edge: SETUP means a setup
// phase was just captured, so the access cycle (pready=1) is on the bus now;
// ACCESS means that access cycle has just completed. The transfer itself
// (write, prdata load, error decision) is done on the edge that captures the
// setup phase, so later changes of paddr/pwdata/pstrb cannot affect it.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int N_REGS     = 8,
    parameter int REGS_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [2:0]              pprot,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [REGS_WIDTH-1:0]   pwdata,
    input  logic [REGS_WIDTH/8-1:0] pstrb,
    output logic [REGS_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int IDX_W = $clog2(N_REGS);

    apb_state_t            state_q;
    decode_t               dec;
    logic [IDX_W-1:0]      idx;
    logic [REGS_WIDTH-1:0] rd_data;
    logic                  start;
    logic                  stray;
    logic                  wr_en;
    logic                  unused_ok;

    assign dec   = decode_addr(64'(paddr), N_REGS);
    assign idx   = dec.idx[IDX_W-1:0];

    // A setup phase starts a transfer unless one was captured at the last
    // edge; penable without a captured setup is an error access.
    assign start = psel && !penable && (state_q != SETUP);
    assign stray = psel &&  penable && (state_q != SETUP);
    assign wr_en = start && pwrite && dec.valid;

    // pprot is accepted and ignored; upper index bits are covered by valid.
    assign unused_ok = ^{pprot, dec.idx};

    apb_reg_bank #(
        .N_REGS     (N_REGS),
        .REGS_WIDTH (REGS_WIDTH)
    ) u_bank (
        .pclk    (pclk),
        .preset  (preset),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (pwdata),
        .wr_strb (pstrb),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    // Bus FSM with registered pready/pslverr/prdata; reset aborts any transfer.
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            case (state_q)
                IDLE, ACCESS: begin
                    if (start) begin
                        state_q <= SETUP;
                        pready  <= 1'b1;
                        pslverr <= !dec.valid;
                        if (!pwrite) begin
                            prdata <= dec.valid ? rd_data : '0;
                        end
                    end else if (stray) begin
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SETUP:   state_q <= ACCESS;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: the driver pushes the expected
// response of every transfer, the monitor pops it when pready shows up.
module tb_apb_reg_slave;

    localparam int N_REGS = 8;

    logic        pclk = 1'b0;
    logic        preset;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    always #5 pclk = ~pclk;

    apb_reg_slave #(
        .N_REGS     (N_REGS),
        .REGS_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .paddr   (paddr),
        .pprot   (pprot),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    typedef struct {
        string       name;
        bit          is_read;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;
    bit   resp_window = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    // Monitor: pready must be high exactly in the response cycle.
    always @(negedge pclk) begin
        if (resp_window) begin
            check("pready_in_access", 32'(pready), 32'd1);
            if (pready === 1'b1 && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, " pslverr"}, 32'(pslverr), 32'(mon_e.err));
                if (mon_e.is_read) check({mon_e.name, " prdata"}, prdata, mon_e.rdata);
            end
        end else if (pready !== 1'b0) begin
            check("pready_outside_access", 32'(pready), 32'd0);
        end
    end

    // Setup then access; access-phase bus values are scrambled on purpose.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] exp_rdata, input bit exp_err);
        string name;
        name = $sformatf("%s@%08h", wr ? "wr" : "rd", addr);
        exp_q.push_back('{name, !wr, exp_rdata, exp_err});
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1; paddr = addr ^ 32'h4; pwdata = ~data; pstrb = ~strb;
        resp_window = 1'b1;
        @(posedge pclk); #1;
        resp_window = 1'b0;
        exp_q.delete();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit err);
        xfer(1'b1, addr, data, strb, 32'h0, err);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input bit err);
        xfer(1'b0, addr, 32'h0, 4'h0, exp_data, err);
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    task automatic reset_pulse(input int n, input string tag);
        psel = 1'b0; penable = 1'b0; preset = 1'b1;
        repeat (n) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        check({tag, " prdata"},  prdata,          32'h0);
        check({tag, " pready"},  32'(pready),     32'h0);
        check({tag, " pslverr"}, 32'(pslverr),    32'h0);
        @(posedge pclk); #1;
    endtask

    logic [31:0] after_err [N_REGS] = '{32'hDEADBEEF, 32'hCAFEBABE, 32'hFF34FF78,
                                        32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    initial begin
        paddr = '0; pprot = 3'b010; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; preset = 1'b1;
        reset_pulse(3, "reset");

        // Basic write/read
        wr(32'h00, 32'hDEADBEEF, 4'hF, 1'b0); idle(1);
        wr(32'h04, 32'hCAFEBABE, 4'hF, 1'b0); idle(1);
        rd(32'h00, 32'hDEADBEEF, 1'b0);       idle(1);
        rd(32'h04, 32'hCAFEBABE, 1'b0);       idle(1);

        // Byte strobes
        wr(32'h08, 32'hFFFFFFFF, 4'hF, 1'b0);    idle(1);
        wr(32'h08, 32'h12345678, 4'b0101, 1'b0); idle(1);
        rd(32'h08, 32'hFF34FF78, 1'b0);          idle(1);

        // Decode errors: out of range, unaligned, high address bits
        wr(32'h20, 32'hAAAAAAAA, 4'hF, 1'b1);     idle(1);
        rd(32'h20, 32'h0, 1'b1);                  idle(1);
        wr(32'h02, 32'h11111111, 4'hF, 1'b1);     idle(1);
        rd(32'h02, 32'h0, 1'b1);                  idle(1);
        wr(32'h1000_0004, 32'h22222222, 4'hF, 1'b1); idle(1);

        // penable without setup: error response, nothing written
        exp_q.push_back('{"stray_penable", 1'b0, 32'h0, 1'b1});
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 32'h0C; pwdata = 32'h77777777; pstrb = 4'hF;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; resp_window = 1'b1;
        @(posedge pclk); #1;
        resp_window = 1'b0;
        exp_q.delete();
        idle(1);

        // All registers unchanged by the error accesses (back-to-back reads)
        for (int i = 0; i < N_REGS; i++) rd(32'(4 * i), after_err[i], 1'b0);
        idle(1);

        // Reset clears registers and prdata
        wr(32'h1C, 32'h55AA55AA, 4'hF, 1'b0); idle(1);
        rd(32'h1C, 32'h55AA55AA, 1'b0);       idle(1);
        reset_pulse(1, "reset_after_write");
        rd(32'h1C, 32'h0, 1'b0);
        rd(32'h00, 32'h0, 1'b0);              idle(1);

        // Reset asserted during a write's access cycle
        exp_q.push_back('{"wr_reset_abort", 1'b0, 32'h0, 1'b0});
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h18; pwdata = 32'h12121212; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1; preset = 1'b1; resp_window = 1'b1;
        @(posedge pclk); #1;
        resp_window = 1'b0; preset = 1'b0; psel = 1'b0; penable = 1'b0;
        exp_q.delete();
        idle(1);
        rd(32'h18, 32'h0, 1'b0); idle(1);

        // Back-to-back writes then reads, no idle cycles between transfers
        for (int i = 0; i < N_REGS; i++) wr(32'(4 * i), 32'h1000 + 32'(i), 4'hF, 1'b0);
        for (int i = 0; i < N_REGS; i++) rd(32'(4 * i), 32'h1000 + 32'(i), 1'b0);

        // Read-after-write in the very next transfer
        wr(32'h10, 32'hA5A5A5A5, 4'hF, 1'b0);
        rd(32'h10, 32'hA5A5A5A5, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
